// File: rtl/mem_bus_arbiter_if.sv
// Wishbone-style bus between the arbiter (master) and the memory slave.
// Signal names keep the master-side _o/_i orientation seen from the arbiter.
interface mem_bus_arbiter_if;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;

  modport master (
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
    input  bus_dat_i, bus_ack_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
    output bus_dat_i, bus_ack_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and data access onto one bus master port.
// Data wins over fetch; a watchdog aborts bus cycles that never see ack.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stall_o,
  input  logic        flush_i,
  mem_bus_arbiter_if.master bus,
  output logic        bus_timeout_o
);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        mem_done_q, if_done_q, discard_q, timeout_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        cyc_q, stb_q, we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q;

  logic [15:0] cnt_d;
  logic        timeout_hit;
  logic        drop_fetch;

  assign cnt_d       = cnt_q + 16'd1;
  // Abort on the TIMEOUT-th consecutive bus cycle without ack.
  assign timeout_hit = 32'(cnt_d) >= TIMEOUT;
  assign drop_fetch  = discard_q | flush_i;

  assign if_stall_o  = if_req_i  & ~if_done_q;
  assign mem_stall_o = mem_req_i & ~mem_done_q;

  assign if_rdata_o    = if_rdata_q;
  assign mem_rdata_o   = mem_rdata_q;
  assign bus_timeout_o = timeout_q;
  assign bus.bus_cyc_o = cyc_q;
  assign bus.bus_stb_o = stb_q;
  assign bus.bus_we_o  = we_q;
  assign bus.bus_sel_o = sel_q;
  assign bus.bus_adr_o = adr_q;
  assign bus.bus_dat_o = dat_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the pulse flags default low and are only raised below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      discard_q   <= 1'b0;
      timeout_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      mem_done_q <= 1'b0;
      if_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          cnt_q     <= '0;
          // A requester whose done is still high must not relaunch.
          if (mem_req_i && !mem_done_q) begin
            state_q <= DATA;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            adr_q   <= mem_addr_i;
            dat_q   <= mem_wdata_i;
          end else if (if_req_i && !if_done_q && !flush_i) begin
            state_q <= INST;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 4'hF;
            adr_q   <= if_addr_i;
            dat_q   <= '0;
          end
        end
        DATA: begin
          if (bus.bus_ack_i || timeout_hit) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            mem_done_q  <= 1'b1;
            timeout_q   <= ~bus.bus_ack_i;
            mem_rdata_q <= (bus.bus_ack_i && !we_q) ? bus.bus_dat_i : '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        INST: begin
          if (flush_i) discard_q <= 1'b1;
          if (bus.bus_ack_i || timeout_hit) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            timeout_q <= ~bus.bus_ack_i;
            if (!drop_fetch) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.bus_ack_i ? bus.bus_dat_i : '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT=4).
// Inputs change 1ns after each rising edge; checks run 1ns later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, mem_req, mem_we, flush;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_stall, mem_stall, bus_timeout;
  int          total = 0;
  int          bad   = 0;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_rdata_o   (if_rdata),
    .if_stall_o   (if_stall),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_sel_i    (mem_sel),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_rdata_o  (mem_rdata),
    .mem_stall_o  (mem_stall),
    .flush_i      (flush),
    .bus          (bus_if.master),
    .bus_timeout_o(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs may be changed right after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [31:0] d);
    bus_if.bus_ack_i = 1'b1;
    bus_if.bus_dat_i = d;
  endtask

  task automatic no_ack();
    bus_if.bus_ack_i = 1'b0;
    bus_if.bus_dat_i = '0;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; mem_req = 0; mem_we = 0; flush = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    no_ack();
    #3;
    check("rst_cyc",     32'(bus_if.bus_cyc_o), 32'd0);
    check("rst_adr",     bus_if.bus_adr_o, 32'd0);
    check("rst_mrdata",  mem_rdata, 32'd0);
    check("rst_timeout", 32'(bus_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Load: ack at cycle 3
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h100;
    #1 check("ld_c0_stall", 32'(mem_stall), 32'd1);
    check("ld_c0_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
    step();
    check("ld_c1_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    check("ld_c1_stb", 32'(bus_if.bus_stb_o), 32'd1);
    check("ld_c1_adr", bus_if.bus_adr_o, 32'h100);
    check("ld_c1_we",  32'(bus_if.bus_we_o), 32'd0);
    step();
    check("ld_c2_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    step();
    check("ld_c3_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    ack(32'hDEADBEEF);
    step();
    no_ack();
    check("ld_c4_cyc",   32'(bus_if.bus_cyc_o), 32'd0);
    check("ld_c4_rdata", mem_rdata, 32'hDEADBEEF);
    check("ld_c4_stall", 32'(mem_stall), 32'd0);
    step();
    mem_req = 0;
    check("ld_c5_norelaunch", 32'(bus_if.bus_cyc_o), 32'd0);
    step();

    // Contention: store first, then fetch
    if_req = 1; if_addr = 32'h2000;
    mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h40; mem_wdata = 32'h1234;
    step();
    check("ct_c1_we",  32'(bus_if.bus_we_o), 32'd1);
    check("ct_c1_sel", 32'(bus_if.bus_sel_o), 32'h3);
    check("ct_c1_adr", bus_if.bus_adr_o, 32'h40);
    check("ct_c1_dat", bus_if.bus_dat_o, 32'h1234);
    check("ct_c1_ifstall", 32'(if_stall), 32'd1);
    ack(32'hFFFFFFFF);
    step();
    no_ack();
    check("ct_c2_cyc",    32'(bus_if.bus_cyc_o), 32'd0);
    check("ct_c2_mstall", 32'(mem_stall), 32'd0);
    check("ct_c2_wrdata", mem_rdata, 32'd0);
    mem_req = 0; mem_we = 0;
    step();
    check("ct_c3_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    check("ct_c3_we",  32'(bus_if.bus_we_o), 32'd0);
    check("ct_c3_sel", 32'(bus_if.bus_sel_o), 32'hF);
    check("ct_c3_adr", bus_if.bus_adr_o, 32'h2000);
    ack(32'hCAFEF00D);
    step();
    no_ack();
    check("ct_c4_ifrdata", if_rdata, 32'hCAFEF00D);
    check("ct_c4_ifstall", 32'(if_stall), 32'd0);
    if_req = 0;
    step();

    // Zero-wait fetch
    if_req = 1; if_addr = 32'h3000;
    #1 check("zw_c0_stall", 32'(if_stall), 32'd1);
    step();
    check("zw_c1_adr",   bus_if.bus_adr_o, 32'h3000);
    check("zw_c1_stall", 32'(if_stall), 32'd1);
    ack(32'h11223344);
    step();
    no_ack();
    check("zw_c2_stall", 32'(if_stall), 32'd0);
    check("zw_c2_rdata", if_rdata, 32'h11223344);
    if_req = 0;
    step();

    // Flush during fetch: response discarded, refetch proceeds
    if_req = 1; if_addr = 32'h4000;
    step();
    check("fl_c1_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    flush = 1;
    step();
    flush = 0;
    check("fl_c2_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    ack(32'hAAAA5555);
    step();
    no_ack();
    check("fl_c3_cyc",   32'(bus_if.bus_cyc_o), 32'd0);
    check("fl_c3_rdata", if_rdata, 32'h11223344);
    check("fl_c3_stall", 32'(if_stall), 32'd1);
    if_addr = 32'h4004;
    step();
    check("fl_c4_adr", bus_if.bus_adr_o, 32'h4004);
    ack(32'h55667788);
    step();
    no_ack();
    check("fl_c5_rdata", if_rdata, 32'h55667788);
    check("fl_c5_stall", 32'(if_stall), 32'd0);
    if_req = 0;
    step();

    // Flush has no effect on a data load
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h180; flush = 1;
    step();
    check("fd_c1_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    ack(32'h0BADF00D);
    step();
    no_ack(); flush = 0;
    check("fd_c2_rdata", mem_rdata, 32'h0BADF00D);
    check("fd_c2_stall", 32'(mem_stall), 32'd0);
    mem_req = 0;
    step();

    // Timeout: cyc high cycles 1-4, abort seen in cycle 5
    mem_req = 1; mem_addr = 32'h500;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("to_c%0d_cyc", c), 32'(bus_if.bus_cyc_o), 32'd1);
      check($sformatf("to_c%0d_pulse", c), 32'(bus_timeout), 32'd0);
    end
    step();
    check("to_c5_pulse", 32'(bus_timeout), 32'd1);
    check("to_c5_cyc",   32'(bus_if.bus_cyc_o), 32'd0);
    check("to_c5_rdata", mem_rdata, 32'd0);
    check("to_c5_stall", 32'(mem_stall), 32'd0);
    mem_req = 0;
    step();
    check("to_c6_pulse", 32'(bus_timeout), 32'd0);

    // Ack coinciding with the timeout cycle wins
    mem_req = 1; mem_addr = 32'h520;
    repeat (3) step();
    step();
    ack(32'h00000077);
    step();
    no_ack();
    check("at_pulse", 32'(bus_timeout), 32'd0);
    check("at_rdata", mem_rdata, 32'h77);
    mem_req = 0;
    step();

    // Ack while idle is ignored
    ack(32'h12121212);
    step();
    no_ack();
    check("ia_cyc",    32'(bus_if.bus_cyc_o), 32'd0);
    check("ia_mrdata", mem_rdata, 32'h77);
    check("ia_pulse",  32'(bus_timeout), 32'd0);
    step();

    // Asynchronous reset mid-transaction, then a clean load
    mem_req = 1; mem_addr = 32'h600;
    step();
    check("rs_c1_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rs_async_cyc",   32'(bus_if.bus_cyc_o), 32'd0);
    check("rs_async_adr",   bus_if.bus_adr_o, 32'd0);
    check("rs_async_mrd",   mem_rdata, 32'd0);
    check("rs_async_ifrd",  if_rdata, 32'd0);
    #1 rst = 1'b1;
    step();
    check("rs_re_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
    check("rs_re_adr", bus_if.bus_adr_o, 32'h600);
    ack(32'h99);
    step();
    no_ack();
    check("rs_re_rdata", mem_rdata, 32'h99);
    check("rs_re_stall", 32'(mem_stall), 32'd0);
    mem_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
